// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the MMIO responder.
//   - address-map constants for the PWM register and the timers
//   - funct3 load/store size/sign encoding
//   - PWM counter/duty width
//   - access_legal(): size/alignment/direction legality of an access
package mmio_pkg;

    localparam logic [31:0] PWM_ADDR    = 32'hFFFF_FFFC;
    localparam logic [31:0] MILLIS_ADDR = 32'hFFFF_FFF8;
    localparam logic [31:0] MICROS_ADDR = 32'hFFFF_FFF4;

    localparam int unsigned PWM_W = 8;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Unsigned load codes have no store counterpart, so they are only legal
    // for loads.
    function automatic logic access_legal(input logic [2:0] f3,
                                          input logic [1:0] off,
                                          input logic       wr);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = !wr;
            F3_HU:   ok = !wr && !off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output with a pending duty register (software view)
// and an active duty register that only reloads at the counter wrap.
//   clk, reset  : clock, synchronous active-high reset
//   wr_en       : load wr_data into the pending duty
//   wr_data     : new duty value
//   count_next  : value the shared counter takes at this edge
//   wrap        : shared counter is at its maximum (reaches 0 at this edge)
//   duty        : pending duty, used for register readback
//   pwm         : registered output, high iff counter < active duty
module pwm_channel
    import mmio_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PWM_W-1:0] wr_data,
    input  logic [PWM_W-1:0] count_next,
    input  logic             wrap,
    output logic [PWM_W-1:0] duty,
    output logic             pwm
);

    logic [PWM_W-1:0] active;
    logic [PWM_W-1:0] active_next;

    always_comb active_next = wrap ? duty : active;

    // The output is computed from next-state values so that the registered
    // pin equals (counter < active) in the same cycle as those registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty   <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr_en) duty <= wr_data;
            active <= active_next;
            pwm    <= (count_next < active_next);
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: data-memory responder with RAM, a 4-channel PWM register
// and optional free-running micros/millis timers (macro MMIO_TIMER_EN).
//   clk, reset      : clock, synchronous active-high reset
//   funct3          : access size/sign code
//   dmem_wren       : store request
//   dmem_address    : byte address
//   dmem_data_in    : right-aligned store data
//   dmem_data_out   : registered load data (1-cycle latency)
//   access_err      : one-cycle pulse on misaligned/illegal access
//   led/red/green/blue : active-high PWM outputs
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned RAM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        access_err,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0]      ram [RAM_WORDS];
    logic [29:0]      word_addr;
    logic [AW-1:0]    ram_idx;
    logic             in_ram;
    logic             pwm_sel;
    logic             legal;
    logic [31:0]      rd_word;
    logic [15:0]      lane;
    logic [31:0]      load_data;
    logic [31:0]      wr_data;
    logic [3:0]       be;
    logic [PWM_W-1:0] pwm_count;
    logic [PWM_W-1:0] duty [4];
    logic [3:0]       pwm_out;

`ifdef MMIO_TIMER_EN
    localparam int unsigned US_DIV = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
    localparam int unsigned MS_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;

    logic [31:0] us_pre;
    logic [31:0] ms_pre;
    logic [31:0] micros;
    logic [31:0] millis;

    always_ff @(posedge clk) begin
        if (reset) begin
            us_pre <= '0;
            ms_pre <= '0;
            micros <= '0;
            millis <= '0;
        end else begin
            if (us_pre == US_DIV - 1) begin
                us_pre <= '0;
                micros <= micros + 1'b1;
            end else begin
                us_pre <= us_pre + 1'b1;
            end
            if (ms_pre == MS_DIV - 1) begin
                ms_pre <= '0;
                millis <= millis + 1'b1;
            end else begin
                ms_pre <= ms_pre + 1'b1;
            end
        end
    end
`else
    logic unused_clk_hz;
    assign unused_clk_hz = ^CLK_HZ;
`endif

    always_comb begin
        word_addr = dmem_address[31:2];
        ram_idx   = dmem_address[AW+1:2];
        in_ram    = ({2'b00, word_addr} < RAM_WORDS);
        pwm_sel   = (word_addr == PWM_ADDR[31:2]);
        legal     = access_legal(funct3, dmem_address[1:0], dmem_wren);

        rd_word = '0;
        if (in_ram) begin
            rd_word = ram[ram_idx];
        end else if (pwm_sel) begin
            rd_word = {duty[3], duty[2], duty[1], duty[0]};
        end
`ifdef MMIO_TIMER_EN
        else if (word_addr == MILLIS_ADDR[31:2]) begin
            rd_word = millis;
        end else if (word_addr == MICROS_ADDR[31:2]) begin
            rd_word = micros;
        end
`endif

        lane = 16'(rd_word >> {dmem_address[1:0], 3'b000});
        case (funct3)
            F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
            F3_W:    load_data = rd_word;
            F3_BU:   load_data = {24'b0, lane[7:0]};
            F3_HU:   load_data = {16'b0, lane[15:0]};
            default: load_data = '0;
        endcase
        if (!legal) load_data = '0;

        wr_data = dmem_data_in << {dmem_address[1:0], 3'b000};
        case (funct3)
            F3_B:    be = 4'b0001 << dmem_address[1:0];
            F3_H:    be = 4'b0011 << dmem_address[1:0];
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!(dmem_wren && legal)) be = '0;
    end

    // RAM has no reset: its contents and a store issued during reset survive.
    always_ff @(posedge clk) begin
        if (in_ram) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) ram[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_data_out <= '0;
            access_err    <= 1'b0;
            pwm_count     <= '0;
        end else begin
            dmem_data_out <= load_data;
            access_err    <= !legal;
            pwm_count     <= pwm_count + 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        pwm_channel u_ch (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (pwm_sel && be[i]),
            .wr_data    (wr_data[8*i +: PWM_W]),
            .count_next (pwm_count + 1'b1),
            .wrap       (pwm_count == '1),
            .duty       (duty[i]),
            .pwm        (pwm_out[i])
        );
    end

    assign led   = pwm_out[0];
    assign red   = pwm_out[1];
    assign green = pwm_out[2];
    assign blue  = pwm_out[3];

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed and randomized checks of mmio_responder against
// a byte-level reference model (memory map, PWM periods, tick-based timers).
module tb_mmio_responder;

`ifdef MMIO_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif
    localparam int unsigned US_DIV = 12;
    localparam int unsigned MS_DIV = 12000;
    localparam logic [31:0] IDLE   = 32'h0000_8000;
    localparam logic [31:0] PWM    = 32'hFFFF_FFFC;
    localparam logic [31:0] MILLIS = 32'hFFFF_FFF8;
    localparam logic [31:0] MICROS = 32'hFFFF_FFF4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  funct3 = 3'd2;
    logic        dmem_wren = 1'b0;
    logic [31:0] dmem_address = IDLE;
    logic [31:0] dmem_data_in = '0;
    logic [31:0] dmem_data_out;
    logic        access_err;
    logic        led, red, green, blue;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]  mem [int unsigned];
    logic [7:0]  pend [4] = '{default: 8'h00};
    logic [7:0]  act  [4] = '{default: 8'h00};
    int unsigned cnt = 0;
    int unsigned t   = 0;
    logic [31:0] last_data;
    logic        last_err;

    mmio_responder #(.CLK_HZ(12000000), .RAM_WORDS(1024)) dut (
        .clk           (clk),
        .reset         (reset),
        .funct3        (funct3),
        .dmem_wren     (dmem_wren),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out),
        .access_err    (access_err),
        .led           (led),
        .red           (red),
        .green         (green),
        .blue          (blue)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] wa);
        if (wa < 32'd4096) return {mem[wa+3], mem[wa+2], mem[wa+1], mem[wa]};
        if (wa == PWM)    return {pend[3], pend[2], pend[1], pend[0]};
        if (wa == MILLIS) return TIMER_EN ? t / MS_DIV : 0;
        if (wa == MICROS) return TIMER_EN ? t / US_DIV : 0;
        return 32'h0;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                               input int unsigned size);
        logic [31:0] v;
        v = model_word(a & ~32'd3) >> (8 * (a % 4));
        if (size == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic store_byte(input logic [31:0] ba, input logic [7:0] b, input logic rst);
        if (ba < 32'd4096) mem[ba] = b;
        else if ((ba & ~32'd3) == PWM && !rst) pend[ba % 4] = b;
    endtask

    // One clock: present an access, advance the model, check the results.
    task automatic step(input logic rst, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        int unsigned size;
        logic        ok;
        logic [31:0] exp_data;
        logic [7:0]  pend_old [4];
        logic [3:0]  exp_pwm;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        ok = (size != 0) && !(wr && f3 > 3'd2);
        if (ok) ok = ((a % size) == 0);
        exp_data = (ok && !rst) ? load_value(f3, a, size) : 32'h0;
        pend_old = pend;
        if (ok && wr) begin
            for (int k = 0; k < int'(size); k++) store_byte(a + k, d[8*k +: 8], rst);
        end
        if (rst) begin
            foreach (pend[i]) begin
                pend[i] = 8'h00;
                act[i]  = 8'h00;
            end
            cnt = 0;
            t   = 0;
        end else begin
            if (cnt == 255) act = pend_old;
            cnt = (cnt + 1) % 256;
            t++;
        end
        for (int i = 0; i < 4; i++) exp_pwm[i] = (cnt < act[i]);

        reset        = rst;
        dmem_wren    = wr;
        funct3       = f3;
        dmem_address = a;
        dmem_data_in = d;
        @(posedge clk);
        #1;
        last_data = dmem_data_out;
        last_err  = access_err;
        check("data", dmem_data_out, exp_data);
        check("err", {31'b0, access_err}, {31'b0, !ok && !rst});
        check("pwm", {28'b0, blue, green, red, led}, {28'b0, exp_pwm});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd2, IDLE, 32'h0);
    endtask

    initial begin
        int          hi [4];
        logic [31:0] a;
        int unsigned r;

        step(1'b1, 1'b0, 3'd2, IDLE, 32'h0);
        step(1'b1, 1'b0, 3'd2, IDLE, 32'h0);
        check("rst_data", dmem_data_out, 32'h0);
        check("rst_err", {31'b0, access_err}, 32'h0);
        check("rst_pwm", {28'b0, blue, green, red, led}, 32'h0);

        // timers: 12000 cycles after reset
        for (int k = 0; k < 12000; k++) idle();
        step(1'b0, 1'b0, 3'd2, MICROS, 32'h0);
        check("micros_12000", last_data, TIMER_EN ? 32'd1000 : 32'd0);
        step(1'b0, 1'b0, 3'd2, MILLIS, 32'h0);
        check("millis_12000", last_data, TIMER_EN ? 32'd1 : 32'd0);
        step(1'b0, 1'b1, 3'd2, MILLIS, 32'h0);
        check("millis_wr_noerr", {31'b0, last_err}, 32'h0);
        step(1'b0, 1'b0, 3'd2, MILLIS, 32'h0);
        check("millis_after_wr", last_data, TIMER_EN ? 32'd1 : 32'd0);

        // fill the low RAM region so every random read hits known data
        for (int w = 0; w < 64; w++) step(1'b0, 1'b1, 3'd2, w * 4, $urandom);

        // load sizes and sign handling
        step(1'b0, 1'b1, 3'd2, 32'h10, 32'h80FF7F01);
        step(1'b0, 1'b0, 3'd0, 32'h10, 32'h0); check("lb_10",  last_data, 32'h00000001);
        step(1'b0, 1'b0, 3'd4, 32'h10, 32'h0); check("lbu_10", last_data, 32'h00000001);
        step(1'b0, 1'b0, 3'd1, 32'h10, 32'h0); check("lh_10",  last_data, 32'h00007F01);
        step(1'b0, 1'b0, 3'd5, 32'h10, 32'h0); check("lhu_10", last_data, 32'h00007F01);
        step(1'b0, 1'b0, 3'd1, 32'h12, 32'h0); check("lh_12",  last_data, 32'hFFFF80FF);
        step(1'b0, 1'b0, 3'd5, 32'h12, 32'h0); check("lhu_12", last_data, 32'h000080FF);
        step(1'b0, 1'b0, 3'd0, 32'h13, 32'h0); check("lb_13",  last_data, 32'hFFFFFF80);

        step(1'b0, 1'b1, 3'd0, 32'h13, 32'h000000AA);
        step(1'b0, 1'b0, 3'd2, 32'h10, 32'h0); check("sb_13_lw", last_data, 32'hAAFF7F01);

        // illegal accesses
        step(1'b0, 1'b0, 3'd1, 32'h11, 32'h0);
        check("lh_11_err", {31'b0, last_err}, 32'h1);
        check("lh_11_data", last_data, 32'h0);
        idle(); check("err_one_cycle", {31'b0, last_err}, 32'h0);
        step(1'b0, 1'b1, 3'd2, 32'h12, 32'hDEADBEEF);
        check("sw_12_err", {31'b0, last_err}, 32'h1);
        step(1'b0, 1'b0, 3'd3, 32'h10, 32'h0);
        check("f3_011_err", {31'b0, last_err}, 32'h1);
        step(1'b0, 1'b1, 3'd4, 32'h10, 32'hFFFFFFFF);
        check("store_lbu_err", {31'b0, last_err}, 32'h1);
        step(1'b0, 1'b0, 3'd2, 32'h10, 32'h0); check("ram_unchanged", last_data, 32'hAAFF7F01);

        // load and store to the same word in one cycle
        step(1'b0, 1'b1, 3'd2, 32'h10, 32'h12345678); check("rw_old", last_data, 32'hAAFF7F01);
        step(1'b0, 1'b0, 3'd2, 32'h10, 32'h0); check("rw_new", last_data, 32'h12345678);

        // RAM boundaries
        step(1'b0, 1'b1, 3'd2, 32'h0, 32'h01020304);
        step(1'b0, 1'b1, 3'd2, 32'hFFC, 32'h0BADF00D);
        step(1'b0, 1'b1, 3'd2, 32'h1000, 32'hFFFFFFFF);
        step(1'b0, 1'b0, 3'd2, 32'hFFC, 32'h0); check("ram_last", last_data, 32'h0BADF00D);
        step(1'b0, 1'b0, 3'd2, 32'h0, 32'h0); check("ram_no_alias", last_data, 32'h01020304);
        step(1'b0, 1'b0, 3'd2, 32'h1000, 32'h0); check("unmapped_0", last_data, 32'h0);

        // partial PWM register stores
        step(1'b0, 1'b1, 3'd2, PWM, 32'h11223344);
        step(1'b0, 1'b1, 3'd0, PWM + 1, 32'h00000055);
        step(1'b0, 1'b0, 3'd2, PWM, 32'h0); check("pwm_sb", last_data, 32'h11225544);
        step(1'b0, 1'b1, 3'd1, PWM + 2, 32'h0000BEEF);
        step(1'b0, 1'b0, 3'd2, PWM, 32'h0); check("pwm_sh", last_data, 32'hBEEF5544);

        // duty cycles over one full period after the next wrap
        step(1'b0, 1'b1, 3'd2, PWM, 32'h00FF4000);
        idle();
        for (int k = 0; k < 300 && cnt != 0; k++) idle();
        hi = '{default: 0};
        for (int k = 0; k < 256; k++) begin
            idle();
            hi[0] += int'(led);
            hi[1] += int'(red);
            hi[2] += int'(green);
            hi[3] += int'(blue);
        end
        check("led_high",   hi[0], 0);
        check("red_high",   hi[1], 64);
        check("green_high", hi[2], 255);
        check("blue_high",  hi[3], 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = $urandom_range(0, 255);
            else if (r == 7) a = PWM + $urandom_range(0, 3);
            else if (r == 8) a = MICROS + $urandom_range(0, 7);
            else             a = 32'h0000_1000 + $urandom_range(0, 63);
            step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        // reset in the middle of a PWM period
        step(1'b0, 1'b1, 3'd2, 32'h20, 32'h5A5AA5A5);
        step(1'b0, 1'b1, 3'd2, PWM, 32'hFFFFFFFF);
        for (int k = 0; k < 600 && !(act[0] == 8'hFF && cnt == 100); k++) idle();
        check("pwm_high_pre_rst", {28'b0, blue, green, red, led}, 32'hF);
        step(1'b1, 1'b1, 3'd2, 32'h24, 32'hCAFEF00D);
        check("rst_outs_low", {28'b0, blue, green, red, led}, 32'h0);
        step(1'b1, 1'b1, 3'd2, PWM, 32'hFFFFFFFF);
        step(1'b0, 1'b0, 3'd2, 32'h20, 32'h0); check("ram_kept", last_data, 32'h5A5AA5A5);
        step(1'b0, 1'b0, 3'd2, 32'h24, 32'h0); check("ram_wr_in_rst", last_data, 32'hCAFEF00D);
        step(1'b0, 1'b0, 3'd2, PWM, 32'h0); check("pwm_wr_in_rst", last_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
